// File: rtl/ptos_serializer.sv
// Parallel-to-serial transmitter: takes a WIDTH-bit word through a load/ready
// handshake and emits it one bit per clock with valid and last-bit framing.
module ptos_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned GAP       = 0,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] P_in,
  input  logic             load,
  output logic             ready,
  output logic             SO,
  output logic             SV,
  output logic             LAST,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GW = 4;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_END  = GW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             so_q, so_d;
  logic             sv_q, sv_d;
  logic             last_q, last_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             accept_c;

  // Bit that leaves the word first, depending on the shift direction.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST != 0) return v[WIDTH-1];
    return v[0];
  endfunction

  // Word after its head bit has been sent; vacated positions fill with 0.
  function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] v);
    if (MSB_FIRST != 0) return v << 1;
    return v >> 1;
  endfunction

  assign accept_c = load & ready_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    so_d    = 1'b0;
    sv_d    = 1'b0;
    last_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_SHIFT;
          so_d    = head_bit(P_in);
          shreg_d = drop_head(P_in);
          cnt_d   = '0;
          sv_d    = 1'b1;
        end
      end

      S_SHIFT: begin
        if (cnt_q != LAST_CNT) begin
          so_d    = head_bit(shreg_q);
          shreg_d = drop_head(shreg_q);
          cnt_d   = cnt_q + CW'(1);
          sv_d    = 1'b1;
          last_d  = (cnt_d == LAST_CNT);
        end else if (GAP > 0) begin
          state_d = S_GAP;
          gap_d   = '0;
          shreg_d = '0;
          cnt_d   = '0;
        end else if (accept_c) begin
          // Back-to-back word: first bit follows the previous LAST directly.
          so_d    = head_bit(P_in);
          shreg_d = drop_head(P_in);
          cnt_d   = '0;
          sv_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_END) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
        gap_d   = '0;
      end
    endcase

    ready_d = (state_d == S_IDLE) ||
              ((GAP == 0) && (state_d == S_SHIFT) && (cnt_d == LAST_CNT));
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      so_q    <= 1'b0;
      sv_q    <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      so_q    <= so_d;
      sv_q    <= sv_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign ready = ready_q;
  assign SO    = so_q;
  assign SV    = sv_q;
  assign LAST  = last_q;
  assign busy  = busy_q;

endmodule
